// File: rtl/w0rm_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_core_pkg
//  Description : Shared definitions for the w0rm core writeback path.
//                - log2_ceil: address-width helper for register counts
//                - wb_src_e : which writeback source owns the write port
//  Revision    : 1.0 - initial release
// ============================================================================
package w0rm_core_pkg;

  // Smallest width able to index 'value' entries; never less than 1 so a
  // single-entry file still gets a legal address bus.
  function automatic int log2_ceil(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/w0rm_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_scoreboard
//  Description : Per-register busy bits tracking outstanding loads.
//                A set (load issue) and a clear (load return) may target the
//                same register in one cycle; the set wins since it belongs
//                to a newer load. A clear that finds the register idle raises
//                the sticky wb_err flag.
//  Ports       : clk, reset          - clock, async active-high reset
//                set_valid/set_addr  - mark a register busy
//                clr_valid/clr_addr  - mark a register idle (load returned)
//                lookup_addr0..2     - registers to query
//                lookup_busy0..2     - busy state of queried registers
//                busy_vec            - full scoreboard contents
//                wb_err              - sticky return-to-idle-register flag
//  Revision    : 1.0 - initial release
// ============================================================================
module w0rm_scoreboard #(
  parameter int NUM_REGISTERS = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_valid,
  input  logic [REG_ADDR_BITS-1:0] set_addr,
  input  logic                     clr_valid,
  input  logic [REG_ADDR_BITS-1:0] clr_addr,
  input  logic [REG_ADDR_BITS-1:0] lookup_addr0,
  input  logic [REG_ADDR_BITS-1:0] lookup_addr1,
  input  logic [REG_ADDR_BITS-1:0] lookup_addr2,
  output logic                     lookup_busy0,
  output logic                     lookup_busy1,
  output logic                     lookup_busy2,
  output logic [NUM_REGISTERS-1:0] busy_vec,
  output logic                     wb_err
);

  logic [NUM_REGISTERS-1:0] r_busy;
  logic [NUM_REGISTERS-1:0] w_set_dec;
  logic [NUM_REGISTERS-1:0] w_clr_dec;
  logic                     r_wb_err;
  logic                     w_clr_idle;

  for (genvar r = 0; r < NUM_REGISTERS; r++) begin : g_decode
    assign w_set_dec[r] = set_valid && (set_addr == REG_ADDR_BITS'(r));
    assign w_clr_dec[r] = clr_valid && (clr_addr == REG_ADDR_BITS'(r));
  end

  // Set is OR-ed in after the clear mask so a same-cycle reissue survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_set_dec | (r_busy & ~w_clr_dec);
    end
  end

  assign w_clr_idle = clr_valid && !r_busy[clr_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_err <= 1'b0;
    end else if (w_clr_idle) begin
      r_wb_err <= 1'b1;
    end
  end

  assign lookup_busy0 = r_busy[lookup_addr0];
  assign lookup_busy1 = r_busy[lookup_addr1];
  assign lookup_busy2 = r_busy[lookup_addr2];
  assign busy_vec     = r_busy;
  assign wb_err       = r_wb_err;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback_arbiter
//  Description : Shares the register file's single write port between the
//                ALU writeback path and the memory load-return path, and
//                tracks outstanding loads so decode can stall on them.
//                Memory has priority; the ALU is promoted after MAX_WAIT
//                consecutive denied cycles so it cannot starve.
//  Ports       : clk, reset                     - clock, async active-high reset
//                reg_file_ready                 - write port can accept a write
//                alu_wb_{valid,ready,addr,data} - ALU writeback handshake
//                mem_wb_{valid,ready,addr,data} - load-return handshake
//                load_issue_{valid,addr}        - load issued to a register
//                chk_addr0/1/chk_addr_wr        - decode registers to check
//                hazard                         - any checked register busy
//                port_write_{addr,enable,data}  - registered write port
//                busy_vec                       - scoreboard contents
//                wb_err                         - sticky load-to-idle error
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter
  import w0rm_core_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_REGISTERS = 16,
  parameter  int MAX_WAIT      = 4,
  localparam int REG_ADDR_BITS = log2_ceil(NUM_REGISTERS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_file_ready,
  input  logic                     alu_wb_valid,
  output logic                     alu_wb_ready,
  input  logic [REG_ADDR_BITS-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]    alu_wb_data,
  input  logic                     mem_wb_valid,
  output logic                     mem_wb_ready,
  input  logic [REG_ADDR_BITS-1:0] mem_wb_addr,
  input  logic [DATA_WIDTH-1:0]    mem_wb_data,
  input  logic                     load_issue_valid,
  input  logic [REG_ADDR_BITS-1:0] load_issue_addr,
  input  logic [REG_ADDR_BITS-1:0] chk_addr0,
  input  logic [REG_ADDR_BITS-1:0] chk_addr1,
  input  logic [REG_ADDR_BITS-1:0] chk_addr_wr,
  output logic                     hazard,
  output logic [REG_ADDR_BITS-1:0] port_write_addr,
  output logic                     port_write_enable,
  output logic [DATA_WIDTH-1:0]    port_write_data,
  output logic [NUM_REGISTERS-1:0] busy_vec,
  output logic                     wb_err
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  wb_src_e                  w_grant;
  logic                     w_alu_promote;
  logic [3:0]               r_alu_wait_cnt;
  logic                     r_wr_en;
  logic [REG_ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;
  logic                     w_busy0;
  logic                     w_busy1;
  logic                     w_busy2;

  assign w_alu_promote = alu_wb_valid && (r_alu_wait_cnt == c_max_wait);

  // Readies are forced low during reset so nothing is acknowledged while
  // state is being cleared.
  always_comb begin
    w_grant = SRC_NONE;
    if (!reset && reg_file_ready) begin
      if (mem_wb_valid && !w_alu_promote) begin
        w_grant = SRC_MEM;
      end else if (alu_wb_valid) begin
        w_grant = SRC_ALU;
      end
    end
  end

  assign alu_wb_ready = (w_grant == SRC_ALU);
  assign mem_wb_ready = (w_grant == SRC_MEM);

  // Counts consecutive cycles the ALU was presenting data but was refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_wait_cnt <= 4'd0;
    end else if (!alu_wb_valid || alu_wb_ready) begin
      r_alu_wait_cnt <= 4'd0;
    end else if (r_alu_wait_cnt != c_max_wait) begin
      r_alu_wait_cnt <= r_alu_wait_cnt + 4'd1;
    end
  end

  // Address/data hold their last value when idle; only enable matters then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= (w_grant != SRC_NONE);
      if (w_grant == SRC_MEM) begin
        r_wr_addr <= mem_wb_addr;
        r_wr_data <= mem_wb_data;
      end else if (w_grant == SRC_ALU) begin
        r_wr_addr <= alu_wb_addr;
        r_wr_data <= alu_wb_data;
      end
    end
  end

  w0rm_scoreboard #(
    .NUM_REGISTERS (NUM_REGISTERS),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_valid    (load_issue_valid),
    .set_addr     (load_issue_addr),
    .clr_valid    (mem_wb_ready),
    .clr_addr     (mem_wb_addr),
    .lookup_addr0 (chk_addr0),
    .lookup_addr1 (chk_addr1),
    .lookup_addr2 (chk_addr_wr),
    .lookup_busy0 (w_busy0),
    .lookup_busy1 (w_busy1),
    .lookup_busy2 (w_busy2),
    .busy_vec     (busy_vec),
    .wb_err       (wb_err)
  );

  assign hazard            = w_busy0 | w_busy1 | w_busy2;
  assign port_write_enable = r_wr_en;
  assign port_write_addr   = r_wr_addr;
  assign port_write_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback_arbiter
//  Description : Directed self-checking bench for regfile_writeback_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_arbiter;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGISTERS = 16;
  localparam int MAX_WAIT      = 4;
  localparam int AW            = 4;

  logic                     clk;
  logic                     reset;
  logic                     reg_file_ready;
  logic                     alu_wb_valid;
  logic                     alu_wb_ready;
  logic [AW-1:0]            alu_wb_addr;
  logic [DATA_WIDTH-1:0]    alu_wb_data;
  logic                     mem_wb_valid;
  logic                     mem_wb_ready;
  logic [AW-1:0]            mem_wb_addr;
  logic [DATA_WIDTH-1:0]    mem_wb_data;
  logic                     load_issue_valid;
  logic [AW-1:0]            load_issue_addr;
  logic [AW-1:0]            chk_addr0;
  logic [AW-1:0]            chk_addr1;
  logic [AW-1:0]            chk_addr_wr;
  logic                     hazard;
  logic [AW-1:0]            port_write_addr;
  logic                     port_write_enable;
  logic [DATA_WIDTH-1:0]    port_write_data;
  logic [NUM_REGISTERS-1:0] busy_vec;
  logic                     wb_err;

  int n_cmp;
  int n_err;

  regfile_writeback_arbiter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGISTERS (NUM_REGISTERS),
    .MAX_WAIT      (MAX_WAIT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .reg_file_ready    (reg_file_ready),
    .alu_wb_valid      (alu_wb_valid),
    .alu_wb_ready      (alu_wb_ready),
    .alu_wb_addr       (alu_wb_addr),
    .alu_wb_data       (alu_wb_data),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_ready      (mem_wb_ready),
    .mem_wb_addr       (mem_wb_addr),
    .mem_wb_data       (mem_wb_data),
    .load_issue_valid  (load_issue_valid),
    .load_issue_addr   (load_issue_addr),
    .chk_addr0         (chk_addr0),
    .chk_addr1         (chk_addr1),
    .chk_addr_wr       (chk_addr_wr),
    .hazard            (hazard),
    .port_write_addr   (port_write_addr),
    .port_write_enable (port_write_enable),
    .port_write_data   (port_write_data),
    .busy_vec          (busy_vec),
    .wb_err            (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int mem_list [5] = '{1, 2, 4, 6, 8};
  int mi;
  logic exp_alu;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    reg_file_ready = 1'b1;
    alu_wb_valid = 1'b1;
    alu_wb_addr = '0;
    alu_wb_data = '0;
    mem_wb_valid = 1'b1;
    mem_wb_addr = '0;
    mem_wb_data = '0;
    load_issue_valid = 1'b0;
    load_issue_addr = '0;
    chk_addr0 = '0;
    chk_addr1 = '0;
    chk_addr_wr = '0;

    // Reset state: readies held low even with both sources valid.
    step();
    step();
    check("rst_alu_rdy", alu_wb_ready, 0);
    check("rst_mem_rdy", mem_wb_ready, 0);
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_en", port_write_enable, 0);
    check("rst_addr", port_write_addr, 0);
    check("rst_data", port_write_data, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_err", wb_err, 0);
    check("rst_hazard", hazard, 0);

    // ALU-only write: one-cycle latency, one-cycle enable pulse.
    step();
    alu_wb_valid = 1'b1;
    alu_wb_addr = 4'd3;
    alu_wb_data = 32'hDEADBEEF;
    #1;
    check("alu_rdy", alu_wb_ready, 1);
    check("alu_mem_rdy", mem_wb_ready, 0);
    step();
    alu_wb_valid = 1'b0;
    check("alu_en", port_write_enable, 1);
    check("alu_addr", port_write_addr, 3);
    check("alu_data", port_write_data, 32'hDEADBEEF);
    step();
    check("alu_en_drop", port_write_enable, 0);

    // Load issue then return to register 5.
    load_issue_valid = 1'b1;
    load_issue_addr = 4'd5;
    step();
    load_issue_valid = 1'b0;
    check("ld_busy", busy_vec, 16'h0020);
    chk_addr0 = 4'd5;
    #1;
    check("ld_hazard", hazard, 1);
    mem_wb_valid = 1'b1;
    mem_wb_addr = 4'd5;
    mem_wb_data = 32'h1234;
    #1;
    check("ld_mem_rdy", mem_wb_ready, 1);
    step();
    mem_wb_valid = 1'b0;
    check("ld_en", port_write_enable, 1);
    check("ld_addr", port_write_addr, 5);
    check("ld_data", port_write_data, 32'h1234);
    check("ld_busy_clr", busy_vec, 0);
    check("ld_hazard_clr", hazard, 0);
    check("ld_err", wb_err, 0);
    chk_addr0 = 4'd0;

    // Starvation: pre-issue loads so every memory return hits a busy register.
    for (int i = 0; i < 5; i++) begin
      load_issue_valid = 1'b1;
      load_issue_addr = AW'(mem_list[i]);
      step();
    end
    load_issue_valid = 1'b0;
    check("sv_busy", busy_vec, 16'h0156);
    alu_wb_valid = 1'b1;
    alu_wb_addr = 4'd10;
    alu_wb_data = 32'hA0A0_0000;
    mem_wb_valid = 1'b1;
    mi = 0;
    mem_wb_addr = AW'(mem_list[0]);
    mem_wb_data = 32'h0000_5555;
    #1;
    for (int k = 1; k <= 6; k++) begin
      exp_alu = (k == 5);
      check("sv_alu_rdy", alu_wb_ready, exp_alu);
      check("sv_mem_rdy", mem_wb_ready, !exp_alu);
      step();
      if (exp_alu) begin
        check("sv_alu_addr", port_write_addr, 10);
        alu_wb_data = 32'hA1A1_0000;
      end else begin
        check("sv_mem_addr", port_write_addr, 64'(mem_list[mi]));
        mi = mi + 1;
        if (mi < 5) mem_wb_addr = AW'(mem_list[mi]);
      end
      if (k == 6) begin
        alu_wb_valid = 1'b0;
        mem_wb_valid = 1'b0;
      end
      #1;
    end
    check("sv_busy_clr", busy_vec, 0);
    check("sv_err", wb_err, 0);

    // Same-cycle issue and return to register 7: busy must stay set.
    load_issue_valid = 1'b1;
    load_issue_addr = 4'd7;
    step();
    mem_wb_valid = 1'b1;
    mem_wb_addr = 4'd7;
    mem_wb_data = 32'h77;
    #1;
    check("sc_mem_rdy", mem_wb_ready, 1);
    step();
    load_issue_valid = 1'b0;
    mem_wb_valid = 1'b0;
    check("sc_busy", busy_vec, 16'h0080);
    check("sc_en", port_write_enable, 1);
    check("sc_err", wb_err, 0);

    // Return to idle register 9: write still happens, error is sticky.
    mem_wb_valid = 1'b1;
    mem_wb_addr = 4'd9;
    mem_wb_data = 32'h99;
    step();
    mem_wb_valid = 1'b0;
    check("err_en", port_write_enable, 1);
    check("err_addr", port_write_addr, 9);
    check("err_flag", wb_err, 1);
    step();
    check("err_sticky", wb_err, 1);
    check("err_en_drop", port_write_enable, 0);

    // Write port stalled for 3 cycles with both sources valid.
    reg_file_ready = 1'b0;
    alu_wb_valid = 1'b1;
    alu_wb_addr = 4'd11;
    alu_wb_data = 32'hB;
    mem_wb_valid = 1'b1;
    mem_wb_addr = 4'd7;
    mem_wb_data = 32'hC;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_alu_rdy", alu_wb_ready, 0);
      check("st_mem_rdy", mem_wb_ready, 0);
      step();
      check("st_en", port_write_enable, 0);
    end
    // ALU has waited 3 cycles: memory wins once more, then ALU is promoted.
    reg_file_ready = 1'b1;
    #1;
    check("st_mem_first", mem_wb_ready, 1);
    step();
    check("st_mem_addr", port_write_addr, 7);
    check("st_mem_data", port_write_data, 32'hC);
    check("st_busy_clr", busy_vec, 0);
    mem_wb_addr = 4'd12;
    #1;
    check("st_alu_prom", alu_wb_ready, 1);
    check("st_mem_held", mem_wb_ready, 0);
    step();
    check("st_alu_addr", port_write_addr, 11);
    check("st_alu_data", port_write_data, 32'hB);
    alu_wb_valid = 1'b0;
    load_issue_valid = 1'b1;
    load_issue_addr = 4'd13;
    #1;
    check("st_mem_rdy", mem_wb_ready, 1);
    step();
    load_issue_valid = 1'b0;
    check("pre_rst_en", port_write_enable, 1);
    check("pre_rst_busy", busy_vec, 16'h2000);

    // Asynchronous reset mid-cycle drops the pending write and scoreboard.
    #3;
    reset = 1'b1;
    #1;
    check("ar_en", port_write_enable, 0);
    check("ar_busy", busy_vec, 0);
    check("ar_err", wb_err, 0);
    check("ar_mem_rdy", mem_wb_ready, 0);
    #2;
    reset = 1'b0;
    mem_wb_valid = 1'b0;
    alu_wb_valid = 1'b1;
    alu_wb_addr = 4'd14;
    alu_wb_data = 32'h0E0E_0E0E;
    #1;
    check("post_alu_rdy", alu_wb_ready, 1);
    step();
    alu_wb_valid = 1'b0;
    check("post_en", port_write_enable, 1);
    check("post_addr", port_write_addr, 14);
    check("post_data", port_write_data, 32'h0E0E_0E0E);
    step();
    check("post_en_drop", port_write_enable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
